// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter, branch-target LUT and Start/Done handshake for the accumulator core.
// Define FETCH_SEQ_PERF_EN to enable the saturating retired-instruction counter on Instr_Count.
module fetch_sequencer #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [PC_W-1:0] Start_Addr,
  input  logic            PC_Jmp_Flag,
  input  logic            PC_Beq_Flag,
  input  logic            LUT_Write_En,
  input  logic            LUT_Load_Hi,
  input  logic            LUT_Read_En,
  input  logic [3:0]      Lut_Idx,
  input  logic [7:0]      Acc_Value,
  input  logic            Halt,
  output logic [PC_W-1:0] PC,
  output logic            Run,
  output logic            Done,
  output logic [15:0]     Instr_Count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] lut_q [LUT_DEPTH];
  logic [PC_W-1:0] lutTarget;
  logic            lutWrite;
  logic            unusedReadEn;

  // The target is read combinationally every cycle, so the read enable carries no information here.
  assign unusedReadEn = LUT_Read_En;

  assign lutTarget = lut_q[Lut_Idx];
  assign lutWrite  = (state_q == RUN) && LUT_Write_En;

  assign PC   = pc_q;
  assign Run  = (state_q == RUN);
  assign Done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          pc_d    = Start_Addr;
          state_d = PRIME;
        end
      end
      PRIME: begin
        state_d = RUN;
      end
      RUN: begin
        if (Halt) begin
          state_d = DONE;
        end else if (PC_Jmp_Flag || PC_Beq_Flag) begin
          pc_d = lutTarget;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      DONE: begin
        if (!Start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Byte-wise loads let the 8-bit accumulator build a full PC_W-bit target in two steps.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else if (lutWrite) begin
      if (LUT_Load_Hi) begin
        lut_q[Lut_Idx][PC_W-1:8] <= Acc_Value[PC_W-9:0];
      end else begin
        lut_q[Lut_Idx][7:0] <= Acc_Value;
      end
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] instrCount_q, instrCount_d;

  always_comb begin
    instrCount_d = instrCount_q;
    if ((state_q == IDLE) && Start) begin
      instrCount_d = '0;
    end else if ((state_q == RUN) && (instrCount_q != 16'hFFFF)) begin
      instrCount_d = instrCount_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      instrCount_q <= '0;
    end else begin
      instrCount_q <= instrCount_d;
    end
  end

  assign Instr_Count = instrCount_q;
`else
  assign Instr_Count = 16'h0000;
`endif

endmodule
